// File: rtl/latch_seq_pkg.sv
// Shared types for the latch bank write sequencer.
// Provides the request opcode and FSM state encodings, plus the timer width helper.
package latch_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_PRESET = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_PULSE = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

  // Width needed to hold the longest phase length minus one (at least 1 bit).
  function automatic int unsigned timer_width(input int unsigned s,
                                              input int unsigned p,
                                              input int unsigned h);
    int unsigned m;
    m = s;
    if (p > m) m = p;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating down-counter shared by all sequencer phases.
// Ports: clk, rst (sync, active-high), load/load_val (reload on phase entry),
//        zero_c (count has reached zero).
module phase_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Stops at zero instead of wrapping, so an idle timer stays expired.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/latch_bank_write_seq.sv
// Converts valid/ready write, clear and preset requests into timed strobes for
// a bank of D/E/RN/SETN latches: LD set up before the strobe, strobe held for a
// pulse width, LD held afterwards.
// Ports: CLK, RST (sync, active-high); REQ_VALID/REQ_READY/REQ_OP/REQ_ADDR/
//        REQ_DATA request channel; LD, LE, LRN, LSETN latch controls;
//        BUSY, DONE, ERR status.
module latch_bank_write_seq
  import latch_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic [1:0]               REQ_OP,
  input  logic [$clog2(DEPTH)-1:0] REQ_ADDR,
  input  logic [WIDTH-1:0]         REQ_DATA,
  output logic [WIDTH-1:0]         LD,
  output logic [DEPTH-1:0]         LE,
  output logic                     LRN,
  output logic                     LSETN,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  state_e          state, state_d;
  op_e             op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            bad_q, bad_d;
  logic [WIDTH-1:0] ld_d;
  logic [DEPTH-1:0] le_d;
  logic            lrn_d, lsetn_d, busy_d, done_d, err_d;
  logic            tmr_load, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            accept;

  assign REQ_READY = (state == ST_IDLE) && !RST;
  assign accept    = REQ_VALID && REQ_READY;

  phase_timer #(.W(TW)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_c   (tmr_zero)
  );

  // Next state, captured request and next registered outputs.
  always_comb begin
    state_d  = state;
    op_d     = op_q;
    addr_d   = addr_q;
    bad_d    = bad_q;
    ld_d     = LD;
    le_d     = '0;
    lrn_d    = 1'b1;
    lsetn_d  = 1'b1;
    done_d   = 1'b0;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_d     = op_e'(REQ_OP);
          addr_d   = REQ_ADDR;
          bad_d    = (op_d == OP_RSVD) ||
                     ((op_d == OP_WRITE) && (32'(REQ_ADDR) >= DEPTH));
          if (op_d == OP_WRITE) ld_d = REQ_DATA;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_PULSE;
          tmr_load = 1'b1;
          tmr_val  = TW'(PULSE_CYC - 1);
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = bad_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so they line up with PULSE;
    // only one of LE/LRN/LSETN can be active for a given op.
    if ((state_d == ST_PULSE) && !bad_d) begin
      case (op_d)
        OP_WRITE:  le_d    = DEPTH'(1) << addr_d;
        OP_CLEAR:  lrn_d   = 1'b0;
        OP_PRESET: lsetn_d = 1'b0;
        default:   ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      op_q   <= OP_WRITE;
      addr_q <= '0;
      bad_q  <= 1'b0;
      LD     <= '0;
      LE     <= '0;
      LRN    <= 1'b1;
      LSETN  <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_d;
      op_q   <= op_d;
      addr_q <= addr_d;
      bad_q  <= bad_d;
      LD     <= ld_d;
      LE     <= le_d;
      LRN    <= lrn_d;
      LSETN  <= lsetn_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
      ERR    <= err_d;
    end
  end

endmodule

// File: tb/tb_latch_bank_write_seq.sv
// Scoreboard bench for latch_bank_write_seq: three instances (default, DEPTH=5,
// SETUP/PULSE/HOLD=3/1/2). Each accepted request pushes its per-cycle expected
// outputs; a negedge monitor pops and compares them.
module tb_latch_bank_write_seq;

  typedef struct packed {
    logic [7:0] ld;
    logic [4:0] le;
    logic       lrn;
    logic       lsetn;
    logic       busy;
    logic       done;
    logic       err;
    logic       ready;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vld;
  logic [1:0] op;
  logic [2:0] addr;
  logic [7:0] data;

  logic [7:0] ld0, ld1, ld2;
  logic [3:0] le0, le2;
  logic [4:0] le1;
  logic lrn0, lrn1, lrn2, lsetn0, lsetn1, lsetn2;
  logic busy0, busy1, busy2, done0, done1, done2, err0, err1, err2;
  logic rdy0, rdy1, rdy2;

  obs_t obs0, obs1, obs2;
  obs_t q0[$], q1[$], q2[$];
  logic [7:0] ld_m [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  latch_bank_write_seq u0 (
    .CLK(clk), .RST(rst), .REQ_VALID(vld[0]), .REQ_READY(rdy0), .REQ_OP(op),
    .REQ_ADDR(addr[1:0]), .REQ_DATA(data), .LD(ld0), .LE(le0), .LRN(lrn0),
    .LSETN(lsetn0), .BUSY(busy0), .DONE(done0), .ERR(err0));

  latch_bank_write_seq #(.DEPTH(5)) u1 (
    .CLK(clk), .RST(rst), .REQ_VALID(vld[1]), .REQ_READY(rdy1), .REQ_OP(op),
    .REQ_ADDR(addr), .REQ_DATA(data), .LD(ld1), .LE(le1), .LRN(lrn1),
    .LSETN(lsetn1), .BUSY(busy1), .DONE(done1), .ERR(err1));

  latch_bank_write_seq #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u2 (
    .CLK(clk), .RST(rst), .REQ_VALID(vld[2]), .REQ_READY(rdy2), .REQ_OP(op),
    .REQ_ADDR(addr[1:0]), .REQ_DATA(data), .LD(ld2), .LE(le2), .LRN(lrn2),
    .LSETN(lsetn2), .BUSY(busy2), .DONE(done2), .ERR(err2));

  assign obs0 = {ld0, 1'b0, le0, lrn0, lsetn0, busy0, done0, err0, rdy0};
  assign obs1 = {ld1, le1, lrn1, lsetn1, busy1, done1, err1, rdy1};
  assign obs2 = {ld2, 1'b0, le2, lrn2, lsetn2, busy2, done2, err2, rdy2};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int s_cyc(input int d);
    return (d == 2) ? 3 : 1;
  endfunction
  function automatic int p_cyc(input int d);
    return (d == 2) ? 1 : 2;
  endfunction
  function automatic int h_cyc(input int d);
    return (d == 2) ? 2 : 1;
  endfunction
  function automatic int depth_of(input int d);
    return (d == 1) ? 5 : 4;
  endfunction
  function automatic logic rdy_of(input int d);
    return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
  endfunction

  task automatic push(input int d, input obs_t e);
    if (d == 0) q0.push_back(e);
    else if (d == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // Expected outputs for the cycles following acceptance, through DONE.
  task automatic push_trace(input int d, input logic [1:0] o,
                            input logic [2:0] a, input logic [7:0] dt);
    obs_t e;
    logic bad;
    bad = (o == 2'b11) || ((o == 2'b00) && (int'(a) >= depth_of(d)));
    if (o == 2'b00) ld_m[d] = dt;
    e = '0;
    e.ld = ld_m[d]; e.lrn = 1'b1; e.lsetn = 1'b1; e.busy = 1'b1;
    for (int i = 0; i < s_cyc(d); i++) push(d, e);
    if (!bad) begin
      case (o)
        2'b00:   e.le = 5'(1) << a;
        2'b01:   e.lrn = 1'b0;
        2'b10:   e.lsetn = 1'b0;
        default: ;
      endcase
    end
    for (int i = 0; i < p_cyc(d); i++) push(d, e);
    e.le = '0; e.lrn = 1'b1; e.lsetn = 1'b1;
    for (int i = 0; i < h_cyc(d); i++) push(d, e);
    e.busy = 1'b0; e.done = 1'b1; e.err = bad; e.ready = 1'b1;
    push(d, e);
  endtask

  // Presents a request (leaves REQ_VALID high) and waits for acceptance.
  task automatic issue(input int d, input logic [1:0] o, input logic [2:0] a,
                       input logic [7:0] dt, output int waited);
    @(negedge clk);
    op = o; addr = a; data = dt; vld[d] = 1'b1;
    waited = 0;
    while (!rdy_of(d) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy_of(d)) begin
      check("accept_timeout", 32'(rdy_of(d)), 32'd1);
      vld[d] = 1'b0;
    end else begin
      @(posedge clk);
      push_trace(d, o, a, dt);
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    vld = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("u0_cycle", 32'(obs0), 32'(e));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("u1_cycle", 32'(obs1), 32'(e));
    end
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("u2_cycle", 32'(obs2), 32'(e));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    obs_t rst_obs;
    rst = 1'b1; vld = '0; op = '0; addr = '0; data = '0;
    for (int i = 0; i < 3; i++) ld_m[i] = '0;
    rst_obs = '0; rst_obs.lrn = 1'b1; rst_obs.lsetn = 1'b1;

    // Reset: two cycles high, outputs at defaults and not ready.
    repeat (2) @(negedge clk);
    check("reset_state_u0", 32'(obs0), 32'(rst_obs));
    check("reset_state_u2", 32'(obs2), 32'(rst_obs));
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(rdy0), 32'd1);

    // Write 0xA5 to addr 2, clear-all, then preset with a held back-to-back write.
    issue(0, 2'b00, 3'd2, 8'hA5, w);
    release_req();
    drain();
    issue(0, 2'b01, 3'd0, 8'hFF, w);
    release_req();
    drain();
    issue(0, 2'b10, 3'd0, 8'h00, w);
    issue(0, 2'b00, 3'd1, 8'h3C, w);
    check("b2b_accept_wait", 32'(w), 32'd4);
    release_req();
    drain();

    // Bad requests: reserved op, and addr == DEPTH on the 5-deep bank.
    issue(0, 2'b11, 3'd1, 8'h55, w);
    release_req();
    drain();
    issue(1, 2'b00, 3'd5, 8'h77, w);
    issue(1, 2'b00, 3'd4, 8'h88, w);
    issue(1, 2'b11, 3'd0, 8'h11, w);
    release_req();
    drain();

    // Reset during PULSE of a write: strobe dropped, no DONE.
    @(negedge clk);
    op = 2'b00; addr = 3'd1; data = 8'h5A; vld[0] = 1'b1;
    check("rst_pre_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    check("rst_t1_le", 32'(le0), 32'h0);
    check("rst_t1_ld", 32'(ld0), 32'h5A);
    @(negedge clk);
    check("rst_t2_le", 32'(le0), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_t3_le", 32'(le0), 32'h0);
    check("rst_t3_ready", 32'(rdy0), 32'd0);
    check("rst_t3_busy", 32'(busy0), 32'd0);
    check("rst_t3_done", 32'(done0), 32'd0);
    check("rst_t3_ld", 32'(ld0), 32'h0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    check("rst_t4_done", 32'(done0), 32'd0);
    for (int i = 0; i < 3; i++) ld_m[i] = '0;

    // Timing sweep 3/1/2, then a second write to confirm recovery after reset.
    issue(2, 2'b00, 3'd3, 8'hC3, w);
    issue(2, 2'b10, 3'd0, 8'h00, w);
    release_req();
    drain();
    issue(0, 2'b00, 3'd3, 8'h96, w);
    release_req();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
